// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with registered read data, occupancy-derived
// status flags and one-cycle overflow/underflow pulses for monitoring.
module async_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    write_enable,
   input  logic                    read_enable,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

   // Storage is deliberately left unreset; only pointers define validity.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_wr_accept;
   logic                  w_rd_accept;
   logic [AW-1:0]         w_waddr;
   logic [AW-1:0]         w_raddr;

   assign w_waddr = r_wptr[AW-1:0];
   assign w_raddr = r_rptr[AW-1:0];

   // Status flags depend only on registered pointers, so no input reaches an output.
   always_comb begin
      w_empty = 1'b0;
      w_full  = 1'b0;
      if (r_wptr == r_rptr) begin
         w_empty = 1'b1;
      end else begin
         w_empty = 1'b0;
      end
      if ((w_waddr == w_raddr) && (r_wptr[AW] != r_rptr[AW])) begin
         w_full = 1'b1;
      end else begin
         w_full = 1'b0;
      end
   end

   // Accept requests only against the flags as registered at the start of the cycle.
   always_comb begin
      w_wr_accept = write_enable & ~w_full;
      w_rd_accept = read_enable  & ~w_empty;
   end

   // Storage write port; a write while full is dropped.
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[w_waddr] <= data_in;
      end else begin
         r_mem[w_waddr] <= r_mem[w_waddr];
      end
   end

   // Pointer advance, registered read data and the error pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr      <= PTR_ZERO;
         r_rptr      <= PTR_ZERO;
         r_data_out  <= {DATA_WIDTH{1'b0}};
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            r_wptr <= r_wptr + PTR_ONE;
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_rd_accept) begin
            r_rptr     <= r_rptr + PTR_ONE;
            r_data_out <= r_mem[w_raddr];
         end else begin
            r_rptr     <= r_rptr;
            r_data_out <= r_data_out;
         end
         r_overflow  <= write_enable & w_full;
         r_underflow <= read_enable  & w_empty;
      end
   end

   assign data_out  = r_data_out;
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = r_wptr - r_rptr;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: scoreboard bench; a queue-based occupancy model predicts every
// cycle's outputs, a separate monitor compares them after each rising edge.
module tb_async_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          write_enable;
   logic          read_enable;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .data_out     (data_out),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   typedef struct {
      logic [DW-1:0] d;
      int            cnt;
      logic          ov;
      logic          un;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] mq[$];
   logic [DW-1:0] last_d;
   int            errors;
   int            checks;
   exp_t          mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge and predict the result.
   task automatic cyc(input logic rst_v, input logic we, input logic re, input logic [DW-1:0] d);
      exp_t e;
      bit   was_full;
      bit   was_empty;
      @(negedge clk);
      reset        = rst_v;
      write_enable = we;
      read_enable  = re;
      data_in      = d;
      if (!rst_v) begin
         mq.delete();
         last_d = '0;
         e.ov   = 1'b0;
         e.un   = 1'b0;
      end else begin
         was_empty = (mq.size() == 0);
         was_full  = (mq.size() == DEPTH);
         e.ov = we && was_full;
         e.un = re && was_empty;
         if (re && !was_empty) last_d = mq.pop_front();
         if (we && !was_full) mq.push_back(d);
      end
      e.d   = last_d;
      e.cnt = mq.size();
      exp_q.push_back(e);
   endtask

   // Assert reset between edges and confirm the asynchronous clear.
   task automatic async_reset_check();
      exp_t e;
      @(negedge clk);
      #2;
      reset        = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      #1;
      chk("async_rst_empty", int'(empty), 1);
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_full", int'(full), 0);
      chk("async_rst_data", int'(data_out), 0);
      mq.delete();
      last_d = '0;
      e.d = '0; e.cnt = 0; e.ov = 1'b0; e.un = 1'b0;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the DUT against the oldest prediction just after each edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("data_out", int'(data_out), int'(mon_e.d));
         chk("count", int'(count), mon_e.cnt);
         chk("empty", int'(empty), (mon_e.cnt == 0) ? 1 : 0);
         chk("full", int'(full), (mon_e.cnt == DEPTH) ? 1 : 0);
         chk("overflow", int'(overflow), int'(mon_e.ov));
         chk("underflow", int'(underflow), int'(mon_e.un));
      end
   end

   initial begin
      errors       = 0;
      checks       = 0;
      last_d       = '0;
      reset        = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      data_in      = '0;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));

      // Single transfer
      cyc(1'b1, 1'b1, 1'b0, 8'hAA);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
      cyc(1'b1, 1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);

      // Underflow
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Wrap-around: groups of 3 writes then reads, pattern i*7
      for (int i = 0; i < 40; i += 3) begin
         for (int k = i; k < i + 3 && k < 40; k++) cyc(1'b1, 1'b1, 1'b0, 8'(k * 7));
         for (int k = i; k < i + 3 && k < 40; k++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
      end

      // Simultaneous at count 4
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 8'(8'h50 + i));
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);

      // Simultaneous at full, then drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
      cyc(1'b1, 1'b1, 1'b1, 8'hEE);
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);

      // Simultaneous at empty
      cyc(1'b1, 1'b1, 1'b1, 8'h3C);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);

      // Random traffic
      for (int i = 0; i < 300; i++)
         cyc(1'b1, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 8'($urandom));

      // Mid-stream asynchronous reset at count 5
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
      async_reset_check();
      cyc(1'b0, 1'b1, 1'b1, 8'h11);
      cyc(1'b1, 1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
